// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store unit: RV32 funct3 codes, FSM states, size/mask helpers.
package mem_access_unit_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SECOND = 2'd1,
      S_RESP   = 2'd2
   } state_e;

   function automatic logic [2:0] size_of(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: size_of = 3'd1;
         F3_H, F3_HU: size_of = 3'd2;
         default:     size_of = 3'd4;
      endcase
   endfunction

   function automatic logic [3:0] size_mask(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: size_mask = 4'b0001;
         F3_H, F3_HU: size_mask = 4'b0011;
         default:     size_mask = 4'b1111;
      endcase
   endfunction

   // Unsigned widths exist only for loads.
   function automatic logic f3_legal(input logic [2:0] f3, input logic we);
      case (f3)
         F3_B, F3_H, F3_W: f3_legal = 1'b1;
         F3_BU, F3_HU:     f3_legal = !we;
         default:          f3_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response handshake plus RAM port A; master = pipeline and RAM side, slave = the unit.
interface mem_access_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [3:0]  ram_we;
   logic [29:0] ram_addr;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_dout,
      input  req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_din
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_dout,
      output req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_din
   );

endinterface

// File: rtl/mem_access_unit_load_align_ext.sv
// Combinational load extractor: selects bytes off.. of {hi,lo} and sign/zero-extends per funct3.
module load_align_ext
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [63:0] both;
   logic [31:0] win;

   assign both = {hi_i, lo_i};
   assign win  = both[{1'b0, off_i, 3'b000} +: 32];

   always_comb begin
      data_o = '0;
      case (funct3_i)
         F3_B:    data_o = {{24{win[7]}}, win[7:0]};
         F3_H:    data_o = {{16{win[15]}}, win[15:0]};
         F3_W:    data_o = win;
         F3_BU:   data_o = {24'h0, win[7:0]};
         F3_HU:   data_o = {16'h0, win[15:0]};
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// RV32 load/store unit driving RAM port A; resp 1 cycle after accept (2 if word-crossing), req_ready low while busy.
// MISALIGN_TRAP_EN: word-crossing requests trap with resp_err instead of splitting into two RAM cycles.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int RAM_AW = 12
) (
   input logic              clk,
   input logic              rst_n,
   mem_access_unit_if.slave bus
);

   state_e      state_q, state_d;
   logic [29:0] addr_q, addr_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  f3_q, f3_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic        cross_q, cross_d;
   logic [3:0]  we2_q, we2_d;
   logic [31:0] din2_q, din2_d;
   logic [31:0] lo_q, lo_d;

   logic [2:0]  req_size;
   logic [7:0]  mask8;
   logic [63:0] din64;
   logic        crossing;
   logic        req_bad;
   logic [31:0] align_hi, align_lo, load_data;

   function automatic logic oor(input logic [29:0] w);
      oor = |(w >> RAM_AW);
   endfunction

   // Lane-shift into a 64-bit window: low half hits the first word, high half the next.
   assign req_size = size_of(bus.req_funct3);
   assign mask8    = {4'b0000, size_mask(bus.req_funct3)} << bus.req_addr[1:0];
   assign din64    = {32'h0, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};
   assign crossing = ({1'b0, bus.req_addr[1:0]} + req_size) > 3'd4;
   assign req_bad  = !f3_legal(bus.req_funct3, bus.req_we) || oor(bus.req_addr[31:2]);

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      off_d         = off_q;
      f3_d          = f3_q;
      we_d          = we_q;
      err_d         = err_q;
      cross_d       = cross_q;
      we2_d         = we2_q;
      din2_d        = din2_q;
      lo_d          = lo_q;
      bus.req_ready = 1'b0;
      bus.ram_we    = 4'b0000;
      bus.ram_din   = 32'h0;
      case (state_q)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               addr_d  = bus.req_addr[31:2];
               off_d   = bus.req_addr[1:0];
               f3_d    = bus.req_funct3;
               we_d    = bus.req_we;
               err_d   = 1'b0;
               cross_d = 1'b0;
               lo_d    = 32'h0;
               state_d = S_RESP;
               if (req_bad) begin
                  err_d = 1'b1;
               end else if (crossing) begin
`ifdef MISALIGN_TRAP_EN
                  err_d = 1'b1;
`else
                  cross_d = 1'b1;
                  we2_d   = mask8[7:4];
                  din2_d  = din64[63:32];
                  state_d = S_SECOND;
                  if (bus.req_we) begin
                     bus.ram_we  = mask8[3:0];
                     bus.ram_din = din64[31:0];
                  end
`endif
               end else if (bus.req_we) begin
                  bus.ram_we  = mask8[3:0];
                  bus.ram_din = din64[31:0];
               end
            end
         end
         S_SECOND: begin
            // Read data of the first word arrives now; the first word is never rolled back.
            addr_d  = addr_q + 30'd1;
            lo_d    = bus.ram_dout;
            state_d = S_RESP;
            if (oor(addr_q + 30'd1)) begin
               err_d = 1'b1;
            end else if (we_q) begin
               bus.ram_we  = we2_q;
               bus.ram_din = din2_q;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.ram_addr = addr_d;

   assign align_hi = cross_q ? bus.ram_dout : 32'h0;
   assign align_lo = cross_q ? lo_q : bus.ram_dout;

   load_align_ext u_align (
      .hi_i     (align_hi),
      .lo_i     (align_lo),
      .off_i    (off_q),
      .funct3_i (f3_q),
      .data_o   (load_data)
   );

   assign bus.resp_valid = (state_q == S_RESP);
   assign bus.resp_err   = bus.resp_valid && err_q;
   assign bus.resp_rdata = (bus.resp_valid && !err_q && !we_q) ? load_data : 32'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         cross_q <= 1'b0;
         we2_q   <= '0;
         din2_q  <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         we_q    <= we_d;
         err_q   <= err_d;
         cross_q <= cross_d;
         we2_q   <= we2_d;
         din2_q  <= din2_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-enabled RAM model and a response scoreboard.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          cyc;
      string       nm;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic init_done = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t q[$];
   logic [31:0] mem [0:4095];

   mem_access_unit_if bus ();

   mem_access_unit #(.RAM_AW(12)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Synchronous RAM, port A: read-before-write, 1-cycle read latency.
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
         init_done <= 1'b1;
      end else begin
         for (int b = 0; b < 4; b++)
            if (bus.ram_we[b]) mem[bus.ram_addr[11:0]][8*b +: 8] <= bus.ram_din[8*b +: 8];
      end
      bus.ram_dout <= mem[bus.ram_addr[11:0]];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.resp_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk({e.nm, "_err"}, {31'h0, bus.resp_err}, {31'h0, e.err});
            chk({e.nm, "_rdata"}, bus.resp_rdata, e.rdata);
            chk({e.nm, "_cycle"}, cyc, e.cyc);
         end
      end
   end

   // lat = 0 means the response is expected to be aborted by reset.
   task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_rd, input int lat);
      int n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_ready"}, {31'h0, bus.req_ready}, 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      if (lat > 0) q.push_back('{e_err, e_rd, cyc + lat, nm});
      #1;
   endtask

   task automatic drop();
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready", {31'h0, bus.req_ready}, 32'd1);
      chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
      chk("rst_resp_err", {31'h0, bus.resp_err}, 32'd0);
      chk("rst_rdata", bus.resp_rdata, 32'h0);
      chk("rst_ram_we", {28'h0, bus.ram_we}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      issue("sw10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1);
      chk("sw10_we", {28'h0, bus.ram_we}, 32'hF);
      chk("sw10_addr", {2'b00, bus.ram_addr}, 32'h4);
      chk("sw10_din", bus.ram_din, 32'hDEADBEEF);
      drop();
      issue("lw10", 1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1);
      chk("lw10_we", {28'h0, bus.ram_we}, 32'h0);
      drop();

      issue("sb23", 1'b1, F3_B, 32'h23, 32'h80, 1'b0, 32'h0, 1);
      chk("sb23_we", {28'h0, bus.ram_we}, 32'h8);
      chk("sb23_din", {24'h0, bus.ram_din[31:24]}, 32'h80);
      chk("sb23_addr", {2'b00, bus.ram_addr}, 32'h8);
      drop();
      issue("lb23", 1'b0, F3_B, 32'h23, 32'h0, 1'b0, 32'hFFFFFF80, 1); drop();
      issue("lbu23", 1'b0, F3_BU, 32'h23, 32'h0, 1'b0, 32'h00000080, 1); drop();
      issue("lh22", 1'b0, F3_H, 32'h22, 32'h0, 1'b0, 32'hFFFF8000, 1); drop();
      issue("lhu22", 1'b0, F3_HU, 32'h22, 32'h0, 1'b0, 32'h00008000, 1); drop();

      issue("sw0e", 1'b1, F3_W, 32'h0E, 32'h11223344, TRAP, 32'h0, TRAP ? 1 : 2);
      chk("sw0e_we1", {28'h0, bus.ram_we}, TRAP ? 32'h0 : 32'hC);
      chk("sw0e_addr1", {2'b00, bus.ram_addr}, 32'h3);
      chk("sw0e_din1", bus.ram_din, TRAP ? 32'h0 : 32'h33440000);
      drop();
      chk("sw0e_we2", {28'h0, bus.ram_we}, TRAP ? 32'h0 : 32'h3);
      chk("sw0e_addr2", {2'b00, bus.ram_addr}, TRAP ? 32'h3 : 32'h4);
      chk("sw0e_din2", bus.ram_din, TRAP ? 32'h0 : 32'h00001122);
      chk("sw0e_busy", {31'h0, bus.req_ready}, 32'd0);
      issue("lw0e", 1'b0, F3_W, 32'h0E, 32'h0, TRAP, TRAP ? 32'h0 : 32'h11223344, TRAP ? 1 : 2);
      chk("lw0e_we", {28'h0, bus.ram_we}, 32'h0);
      drop();
      chk("lw0e_busy", {31'h0, bus.req_ready}, 32'd0);
      issue("lh23", 1'b0, F3_H, 32'h23, 32'h0, TRAP, TRAP ? 32'h0 : 32'h00000080, TRAP ? 1 : 2);
      drop();

      issue("lh_oor", 1'b0, F3_H, 32'h1000_0000, 32'h0, 1'b1, 32'h0, 1);
      chk("lh_oor_we", {28'h0, bus.ram_we}, 32'h0);
      drop();
      issue("f3_011", 1'b0, 3'b011, 32'h20, 32'h0, 1'b1, 32'h0, 1); drop();
      issue("st_bu", 1'b1, F3_BU, 32'h20, 32'hFF, 1'b1, 32'h0, 1);
      chk("st_bu_we", {28'h0, bus.ram_we}, 32'h0);
      drop();

      issue("sw3ffe", 1'b1, F3_W, 32'h3FFE, 32'hCAFEF00D, 1'b1, 32'h0, TRAP ? 1 : 2);
      chk("sw3ffe_we1", {28'h0, bus.ram_we}, TRAP ? 32'h0 : 32'hC);
      drop();
      chk("sw3ffe_we2", {28'h0, bus.ram_we}, 32'h0);
      chk("sw3ffe_addr2", {2'b00, bus.ram_addr}, TRAP ? 32'hFFF : 32'h1000);

      issue("sw4d", 1'b1, F3_W, 32'h4D, 32'hAABBCCDD, TRAP, 32'h0, 0);
      chk("sw4d_we1", {28'h0, bus.ram_we}, TRAP ? 32'h0 : 32'hE);
      chk("sw4d_din1", bus.ram_din, TRAP ? 32'h0 : 32'hBBCCDD00);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("abort_we", {28'h0, bus.ram_we}, 32'h0);
      chk("abort_resp", {31'h0, bus.resp_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("abort_ready", {31'h0, bus.req_ready}, 32'd1);
      repeat (3) @(negedge clk);
      chk("abort_word2", mem[12'h014], 32'h0);
      chk("abort_word1", mem[12'h013], TRAP ? 32'h0 : 32'hBBCCDD00);
      issue("lw4c", 1'b0, F3_W, 32'h4C, 32'h0, 1'b0, TRAP ? 32'h0 : 32'hBBCCDD00, 1);
      drop();

      repeat (3) @(negedge clk);
      chk("mem_w3", mem[12'h003], TRAP ? 32'h0 : 32'h33440000);
      chk("mem_w4", mem[12'h004], TRAP ? 32'hDEADBEEF : 32'hDEAD1122);
      chk("mem_wfff", mem[12'hFFF], TRAP ? 32'h0 : 32'hF00D0000);

      n = 0;
      while (q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("queue_empty", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
